// File: rtl/wb_host_pkg.sv
// Shared types and sizing helpers for the Wishbone classic host master.
package wb_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  // The counter has to be able to hold TIMEOUT_CYCLES itself.
  function automatic int timeout_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/wb_host_timeout.sv
// Ack-wait counter: cleared on command accept, counts BUS cycles without ack.
// expired is combinational and fires in the cycle whose closing edge reaches TIMEOUT_CYCLES.
module wb_host_timeout
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone B3 classic single-transfer initiator: cmd valid/ready in, rsp valid/ready out, one transfer in flight.
// Zero-wait slave gives rsp_valid two cycles after accept; optional ack timeout under WB_TIMEOUT_EN.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter  int ADDR_W         = WB_ADDR_W,
  parameter  int DATA_W         = WB_DATA_W,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int SEL_W          = DATA_W / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_host_master: TIMEOUT_CYCLES must be >= 1");
  end

  state_e state_q, state_d;
  logic   accept;
  logic   tmo_expired;

  assign accept = (state_q == IDLE) && cmd_valid;

`ifdef WB_TIMEOUT_EN
  wb_host_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (accept),
    .en     ((state_q == BUS) && !wbm_ack_i),
    .expired(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = BUS;
      BUS:     if (wbm_ack_i || tmo_expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so cyc/stb drop on the ack edge.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
    wbm_cyc_o = (state_q == BUS);
    wbm_stb_o = (state_q == BUS);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      wbm_we_o  <= cmd_we;
      wbm_adr_o <= cmd_adr;
      wbm_dat_o <= cmd_dat;
      wbm_sel_o <= cmd_sel;
    end else if (state_q == BUS) begin
      // Ack takes priority over a timeout landing in the same cycle.
      if (wbm_ack_i) begin
        rsp_rdata <= wbm_we_o ? '0 : wbm_dat_i;
        rsp_err   <= 1'b0;
      end else if (tmo_expired) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master; responses checked by a scoreboard monitor at rsp handshakes.
module tb_wb_host_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic        busy;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_host_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string name, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    check({name, ".cyc_stb"}, {62'd0, wbm_cyc_o, wbm_stb_o}, 64'd3);
    check({name, ".we"}, {63'd0, wbm_we_o}, {63'd0, we});
    check({name, ".adr"}, {32'd0, wbm_adr_o}, {32'd0, adr});
    check({name, ".sel"}, {60'd0, wbm_sel_o}, {60'd0, sel});
    if (we) check({name, ".dat"}, {32'd0, wbm_dat_o}, {32'd0, dat});
    check({name, ".rdy_busy"}, {62'd0, cmd_ready, busy}, 64'd1);
  endtask

  task automatic drive_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
  endtask

  task automatic check_idle_quiet(input string name);
    check({name, ".wbm"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o},
          {3'b000, 32'd0, 4'd0});
    check({name, ".wbm_dat"}, {32'd0, wbm_dat_o}, 64'd0);
    check({name, ".ctl"}, {61'd0, cmd_ready, rsp_valid, busy}, 64'b100);
  endtask

  // Scoreboard monitor: every accepted response must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rsp", {31'd0, rsp_rdata, rsp_err}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
        check("sb_err", {63'd0, rsp_err}, {63'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1; wbm_dat_i = 32'hCAFE_0000; wbm_ack_i = 1'b0;
    tick(); tick();
    check_idle_quiet("reset");
    check("reset.rsp", {31'd0, rsp_rdata, rsp_err}, 64'd0);
    rst = 1'b0;

    // Stray ack while idle.
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    tick();
    check("stray_idle", {61'd0, rsp_valid, busy, cmd_ready}, 64'b001);

    // Write with two wait states.
    drive_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    tick();
    cmd_valid = 1'b0; cmd_dat = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check_bus("write_bus", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
      if (i == 2) wbm_ack_i = 1'b1;
      tick();
    end
    wbm_ack_i = 1'b0;
    check("write_rsp", {61'd0, rsp_valid, wbm_cyc_o, wbm_stb_o}, 64'b100);
    tick();
    check("write_done", {62'd0, cmd_ready, rsp_valid}, 64'b10);

    // Zero-wait read.
    drive_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    sb_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    tick();
    cmd_valid = 1'b0;
    check_bus("read_bus", 1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
    tick();
    wbm_ack_i = 1'b0; wbm_dat_i = 32'hFFFF_0000;
    check("read_latency", {62'd0, rsp_valid, wbm_cyc_o}, 64'b10);
    check("read_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
    tick();

    // Response backpressure with a new command waiting.
    rsp_ready = 1'b0;
    drive_cmd(1'b0, 32'h3000_000C, 32'h0, 4'h3);
    sb_q.push_back('{rdata: 32'hA5A5_0F0F, err: 1'b0});
    tick();
    drive_cmd(1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'hC);
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_0F0F;
    tick();
    wbm_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wbm_dat_i = 32'h1111_1111 * (i + 1);
      check("bp_hold", {30'd0, rsp_valid, cmd_ready, rsp_rdata}, {2'b10, 32'hA5A5_0F0F});
      tick();
    end
    rsp_ready = 1'b1;
    check("bp_handshake_cycle", {62'd0, rsp_valid, cmd_ready}, 64'b10);
    tick();
    check("bp_after", {62'd0, cmd_ready, busy}, 64'b10);
    tick();
    cmd_valid = 1'b0;
    check_bus("bp_next_cmd", 1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'hC);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    check("bp_next_rsp", {63'd0, rsp_valid}, 64'd1);
    tick();

    // Reset in the middle of a bus cycle; a late ack must not produce a response.
    drive_cmd(1'b1, 32'h3000_0020, 32'h7777_8888, 4'h1);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rst_mid_busy", {62'd0, wbm_cyc_o, busy}, 64'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_quiet("rst_mid");
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    tick();
    check("rst_late_ack", {62'd0, rsp_valid, busy}, 64'b00);

`ifdef WB_TIMEOUT_EN
    // No ack: timeout after four BUS cycles.
    drive_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    sb_q.push_back('{rdata: 32'h0, err: 1'b1});
    wbm_dat_i = 32'h9999_9999;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_cyc_held", {63'd0, wbm_cyc_o}, 64'd1);
      tick();
    end
    check("tmo_rsp", {29'd0, wbm_cyc_o, rsp_valid, rsp_err, rsp_rdata}, {3'b011, 32'h0});
    tick();

    // Ack on the fourth cycle beats the timeout.
    drive_cmd(1'b0, 32'h3000_0034, 32'h0, 4'hF);
    sb_q.push_back('{rdata: 32'h5555_AAAA, err: 1'b0});
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_ack_cyc_held", {63'd0, wbm_cyc_o}, 64'd1);
      if (i == 3) begin
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h5555_AAAA;
      end
      tick();
    end
    wbm_ack_i = 1'b0;
    check("tmo_ack_rsp", {62'd0, rsp_valid, rsp_err}, 64'b10);
    tick();
`endif

    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
